// File: rtl/fbank_owner_arb.sv
// Feature-map bank ownership arbiter: grants the bank write port to one
// channel at a time. The host channel owns the bank when no one else does.
module fbank_owner_arb #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned HOST_CH = 0,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*ADDR_W-1:0]   m_waddr,
  input  logic [N_CH*DATA_W-1:0]   m_wdata,
  input  logic [N_CH-1:0]          m_wen,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          rel,
  output logic [ADDR_W-1:0]        bank_waddr,
  output logic [DATA_W-1:0]        bank_wdata,
  output logic                     bank_wen,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] owner,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned OW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [N_CH-1:0] HOST_MASK = {{(N_CH-1){1'b0}}, 1'b1} << HOST_CH;

  typedef enum logic [1:0] {IDLE, HANDOFF, OWNED} state_t;

  state_t            state, state_n;
  logic [OW-1:0]     owner_n;
  logic              busy_n, terr_n;
  logic [N_CH-1:0]   pend, pend_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [N_CH-1:0]   own_mask, req_nh;
  logic              rel_own, req_own, wd_hit;
  logic [OW-1:0]     sel;

  function automatic logic [OW-1:0] lowest(input logic [N_CH-1:0] m);
    logic [OW-1:0] r;
    r = OW'(HOST_CH);
    for (int i = N_CH - 1; i >= 0; i--) if (m[i]) r = OW'(i);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [OW-1:0] o);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (o == OW'(i));
    return r;
  endfunction

  // Bank write-port mux follows the registered owner; writes blocked in HANDOFF.
  always_comb begin
    bank_waddr = '0;
    bank_wdata = '0;
    bank_wen   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (owner == OW'(i)) begin
        bank_waddr = m_waddr[i*ADDR_W +: ADDR_W];
        bank_wdata = m_wdata[i*DATA_W +: DATA_W];
        bank_wen   = m_wen[i] && (state != HANDOFF);
      end
    end
  end

  always_comb begin
    own_mask = onehot(owner);
    req_nh   = req & ~HOST_MASK;
    rel_own  = |(rel & own_mask);
    req_own  = |(req & own_mask);
    wd_hit   = (TIMEOUT != 0) && (state == OWNED) && (cnt == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    owner_n = owner;
    busy_n  = busy;
    terr_n  = timeout_err;
    pend_n  = pend;
    cnt_n   = cnt;
    sel     = OW'(HOST_CH);
    case (state)
      IDLE: begin
        pend_n = pend | req_nh;
        if (pend_n != '0) begin
          sel     = lowest(pend_n);
          pend_n  = pend_n & ~onehot(sel);
          owner_n = sel;
          busy_n  = 1'b1;
          state_n = HANDOFF;
        end
      end
      HANDOFF: begin
        pend_n = pend | (req_nh & ~own_mask);
        if (owner != OW'(HOST_CH)) begin
          state_n = OWNED;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      OWNED: begin
        pend_n = pend | (req_nh & ~own_mask);
        cnt_n  = cnt + CNT_W'(1);
        if (wd_hit) terr_n = 1'b1;
        if (rel_own || wd_hit) begin
          // Owner's own re-request only queues; it is granted later by priority.
          if (req_own) pend_n = pend_n | own_mask;
          state_n = HANDOFF;
          if (pend != '0) begin
            sel     = lowest(pend);
            pend_n  = pend_n & ~onehot(sel);
            owner_n = sel;
            busy_n  = 1'b1;
          end else begin
            owner_n = OW'(HOST_CH);
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OW'(HOST_CH);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      pend        <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
      pend        <= pend_n;
      cnt         <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fbank_owner_arb.sv
// Directed bench for fbank_owner_arb with 3 channels, host 0, watchdog 16.
module tb_fbank_owner_arb;

  localparam int unsigned N_CH   = 3;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_CH*ADDR_W-1:0]  m_waddr;
  logic [N_CH*DATA_W-1:0]  m_wdata;
  logic [N_CH-1:0]         m_wen;
  logic [N_CH-1:0]         req;
  logic [N_CH-1:0]         rel;
  logic [ADDR_W-1:0]       bank_waddr;
  logic [DATA_W-1:0]       bank_wdata;
  logic                    bank_wen;
  logic [1:0]              owner;
  logic                    busy;
  logic                    timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  fbank_owner_arb #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_CH(0), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wen(m_wen),
    .req(req), .rel(rel),
    .bank_waddr(bank_waddr), .bank_wdata(bank_wdata), .bank_wen(bank_wen),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [N_CH-1:0] m);
    req = m;
    step();
    req = '0;
  endtask

  task automatic pulse_rel(input logic [N_CH-1:0] m);
    rel = m;
    step();
    rel = '0;
  endtask

  task automatic expect_state(input string tag, input int o, input int b, input int w);
    check({tag, "_owner"}, 32'(owner), 32'(o));
    check({tag, "_busy"},  32'(busy),  32'(b));
    check({tag, "_wen"},   32'(bank_wen), 32'(w));
  endtask

  initial begin
    m_waddr = {15'h2222, 15'h1111, 15'h0100};
    m_wdata = {8'hC2, 8'hB1, 8'hA0};
    m_wen   = 3'b111;
    req = '0;
    rel = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state: host owns the bank
    expect_state("reset", 0, 0, 1);
    check("reset_terr", 32'(timeout_err), 0);
    check("reset_addr", 32'(bank_waddr), 32'h0100);
    check("reset_data", 32'(bank_wdata), 32'hA0);

    // Single request: HANDOFF then OWNED
    pulse_req(3'b010);
    expect_state("grant1_handoff", 1, 1, 0);
    step();
    expect_state("grant1_owned", 1, 1, 1);
    check("grant1_addr", 32'(bank_waddr), 32'h1111);
    check("grant1_data", 32'(bank_wdata), 32'hB1);
    m_wen = 3'b101;
    #1;
    check("grant1_wen_follow", 32'(bank_wen), 0);
    m_wen = 3'b111;

    // Queued request handed over on release
    pulse_req(3'b100);
    check("queue2_owner", 32'(owner), 1);
    pulse_rel(3'b001);
    expect_state("host_rel_ignored", 1, 1, 1);
    pulse_rel(3'b010);
    expect_state("hand2_handoff", 2, 1, 0);
    step();
    expect_state("hand2_owned", 2, 1, 1);
    check("hand2_addr", 32'(bank_waddr), 32'h2222);

    // Non-owner releases ignored; owner release returns to host
    pulse_rel(3'b010);
    pulse_rel(3'b001);
    expect_state("nonowner_rel", 2, 1, 1);
    pulse_rel(3'b100);
    expect_state("back_host_handoff", 0, 0, 0);
    step();
    expect_state("back_host_idle", 0, 0, 1);
    step();
    check("idle_stays", 32'(owner), 0);

    // Simultaneous requests: lowest index first, direct handoff to next
    pulse_req(3'b110);
    expect_state("simul_first", 1, 1, 0);
    step();
    pulse_rel(3'b010);
    expect_state("simul_second", 2, 1, 0);
    step();
    expect_state("simul_second_owned", 2, 1, 1);
    pulse_rel(3'b100);
    check("simul_done", 32'(owner), 0);
    step();

    // Same-cycle release and re-request by owner: re-granted after a host pass
    pulse_req(3'b010);
    step();
    req = 3'b010;
    rel = 3'b010;
    step();
    req = '0;
    rel = '0;
    expect_state("rerq_handoff_host", 0, 0, 0);
    step();
    check("rerq_idle_owner", 32'(owner), 0);
    step();
    expect_state("rerq_regrant", 1, 1, 0);
    step();
    pulse_rel(3'b010);
    step();
    step();
    check("rerq_clean_idle", 32'(owner), 0);

    // Watchdog: 16 OWNED cycles without release
    pulse_req(3'b010);
    step();
    for (int i = 0; i < 15; i++) step();
    check("wd_before_owner", 32'(owner), 1);
    check("wd_before_terr", 32'(timeout_err), 0);
    step();
    expect_state("wd_fire", 0, 0, 0);
    check("wd_terr", 32'(timeout_err), 1);
    step();
    pulse_req(3'b100);
    step();
    pulse_rel(3'b100);
    step();
    check("wd_sticky", 32'(timeout_err), 1);

    // Reset mid-ownership with a pending request
    pulse_req(3'b010);
    step();
    pulse_req(3'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_state("rst_abort", 0, 0, 1);
    check("rst_terr_clear", 32'(timeout_err), 0);
    step();
    step();
    check("rst_no_grant2", 32'(owner), 0);

    // Requests during reset are discarded
    rst = 1'b1;
    req = 3'b100;
    step();
    rst = 1'b0;
    req = '0;
    step();
    step();
    check("rst_req_dropped", 32'(owner), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
